// File: rtl/ptb_waveform_capture.sv
// Waveform capture: on an accepted trigger, writes n delayed samples and a 3-word timestamp trailer into the waveform FIFO.
// Latency: ptb_in at cycle k appears on wr_data/wr_en at cycle k+1, so an event is n_written+3 back-to-back writes.
// Backpressure: none while an event runs. A trigger is accepted only if fifo_space already covers the whole event.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   ptb_in, ptb_rdy       delayed sample stream from pretrigger_buffer and its primed flag
//   arm, trig             capture enable; one-cycle trigger pulse
//   n_samples, ltc        event length and timestamp, latched when a trigger is accepted
//   fifo_space            free words in the downstream FIFO
//   wr_en, wr_data        FIFO write port; wr_data = {tag[1:0], payload}
//   busy                  high whenever the FSM is not IDLE
//   drop_cnt              saturating count of rejected triggers
module ptb_waveform_capture #(
  parameter int P_DATA_WIDTH  = 22,
  parameter int P_LEN_WIDTH   = 8,
  parameter int P_SPACE_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [P_DATA_WIDTH-1:0]  ptb_in,
  input  logic                     ptb_rdy,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [P_LEN_WIDTH-1:0]   n_samples,
  input  logic [47:0]              ltc,
  input  logic [P_SPACE_WIDTH-1:0] fifo_space,
  output logic                     wr_en,
  output logic [P_DATA_WIDTH+1:0]  wr_data,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  // The space comparison needs one bit more than the wider operand so that n_samples+3 cannot wrap.
  localparam int CMP_W = ((P_SPACE_WIDTH > P_LEN_WIDTH) ? P_SPACE_WIDTH : P_LEN_WIDTH) + 1;

  localparam logic [1:0] TAG_SOF = 2'b10;
  localparam logic [1:0] TAG_MID = 2'b00;
  localparam logic [1:0] TAG_EOF = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    TRL0,
    TRL1,
    TRL2
  } state_t;

  state_t                    state, state_nxt;
  logic [P_LEN_WIDTH-1:0]    n_lat, n_lat_nxt;
  logic [P_LEN_WIDTH-1:0]    n_wr, n_wr_nxt;
  logic [P_LEN_WIDTH-1:0]    n_wr_inc;
  logic [47:0]               ltc_lat, ltc_lat_nxt;
  logic                      aborted, aborted_nxt;
  logic                      wr_en_nxt;
  logic [P_DATA_WIDTH+1:0]   wr_data_nxt;
  logic [15:0]               drop_cnt_nxt;

  logic                      trig_armed;
  logic                      space_ok;
  logic                      accept;
  logic                      drop;
  logic [P_DATA_WIDTH-1:0]   trl0_pay, trl1_pay, trl2_pay;

  assign trig_armed = trig & arm;
  assign space_ok   = CMP_W'(fifo_space) >= (CMP_W'(n_samples) + CMP_W'(3));
  assign accept     = (state == IDLE) && trig_armed && ptb_rdy && (n_samples != '0) && space_ok;
  // Any armed trigger that is not accepted is a drop, including one that arrives mid-event.
  assign drop       = trig_armed && !accept;
  assign busy       = (state != IDLE);
  assign n_wr_inc   = n_wr + P_LEN_WIDTH'(1);

  assign trl0_pay = ltc_lat[47:26];
  assign trl1_pay = ltc_lat[25:4];
  assign trl2_pay = {ltc_lat[3:0], aborted, 9'b0, n_wr[7:0]};

  always_comb begin
    state_nxt    = state;
    n_lat_nxt    = n_lat;
    n_wr_nxt     = n_wr;
    ltc_lat_nxt  = ltc_lat;
    aborted_nxt  = aborted;
    wr_en_nxt    = 1'b0;
    wr_data_nxt  = wr_data;
    drop_cnt_nxt = drop_cnt;

    if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt_nxt = drop_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        // The trigger cycle's own sample is the first word, so it is written straight from IDLE.
        // A one-sample event therefore has nothing left to capture and goes directly to the trailer.
        if (accept) begin
          n_lat_nxt   = n_samples;
          ltc_lat_nxt = ltc;
          aborted_nxt = 1'b0;
          n_wr_nxt    = P_LEN_WIDTH'(1);
          wr_en_nxt   = 1'b1;
          wr_data_nxt = {TAG_SOF, ptb_in};
          state_nxt   = (n_samples == P_LEN_WIDTH'(1)) ? TRL0 : CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en_nxt = 1'b1;
        if (!ptb_rdy) begin
          // The buffer is being reconfigured, so this cycle's sample is invalid. TRL0 takes its
          // write slot, which keeps the event free of gaps.
          aborted_nxt = 1'b1;
          wr_data_nxt = {TAG_MID, trl0_pay};
          state_nxt   = TRL1;
        end else begin
          wr_data_nxt = {TAG_MID, ptb_in};
          n_wr_nxt    = n_wr_inc;
          if (n_wr_inc == n_lat) begin
            state_nxt = TRL0;
          end
        end
      end
      TRL0: begin
        wr_en_nxt   = 1'b1;
        wr_data_nxt = {TAG_MID, trl0_pay};
        state_nxt   = TRL1;
      end
      TRL1: begin
        wr_en_nxt   = 1'b1;
        wr_data_nxt = {TAG_MID, trl1_pay};
        state_nxt   = TRL2;
      end
      TRL2: begin
        // EOF goes out as the FSM returns to IDLE, so a trigger in the next cycle can follow back-to-back.
        wr_en_nxt   = 1'b1;
        wr_data_nxt = {TAG_EOF, trl2_pay};
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_lat    <= '0;
      n_wr     <= '0;
      ltc_lat  <= '0;
      aborted  <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      n_lat    <= n_lat_nxt;
      n_wr     <= n_wr_nxt;
      ltc_lat  <= ltc_lat_nxt;
      aborted  <= aborted_nxt;
      wr_en    <= wr_en_nxt;
      wr_data  <= wr_data_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ptb_waveform_capture.sv
// Bench for ptb_waveform_capture: stimulus tables per segment, expected writes from an event-level model.
// Latency: outputs are checked each cycle against the model, which places each write one cycle after its source sample.
// Backpressure: none modelled; fifo_space only decides whether a trigger is accepted.
module tb_ptb_waveform_capture;

  localparam int MAXN = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] ptb_in;
  logic        ptb_rdy;
  logic        arm;
  logic        trig;
  logic [7:0]  n_samples;
  logic [47:0] ltc;
  logic [11:0] fifo_space;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        busy;
  logic [15:0] drop_cnt;

  ptb_waveform_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ptb_in     (ptb_in),
    .ptb_rdy    (ptb_rdy),
    .arm        (arm),
    .trig       (trig),
    .n_samples  (n_samples),
    .ltc        (ltc),
    .fifo_space (fifo_space),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Per-cycle stimulus table for one segment
  int          seg_len;
  logic [21:0] s_ptb   [MAXN];
  logic        s_rdy   [MAXN];
  logic        s_arm   [MAXN];
  logic        s_trig  [MAXN];
  logic [7:0]  s_n     [MAXN];
  logic [47:0] s_ltc   [MAXN];
  logic [11:0] s_space [MAXN];

  // Expected outputs visible during cycle c
  logic        e_wr   [MAXN+1];
  logic [23:0] e_dat  [MAXN+1];
  logic        e_busy [MAXN+1];
  logic [15:0] e_drop [MAXN+1];

  int          m_drop;
  logic [23:0] wlog[$];

  task automatic seg_default(input int len);
    seg_len = len;
    for (int c = 0; c < MAXN; c++) begin
      s_ptb[c]   = 22'($urandom);
      s_rdy[c]   = 1'b1;
      s_arm[c]   = 1'b1;
      s_trig[c]  = 1'b0;
      s_n[c]     = 8'd4;
      s_ltc[c]   = 48'h123456789ABC;
      s_space[c] = 12'hFFF;
    end
  endtask

  // Event-level model. An accepted trigger at t produces w sample words at t+1..t+w,
  // followed by three trailer words. The FSM is free again at t+w+3.
  task automatic build_expect();
    int   free_at;
    int   drops;
    int   n;
    int   w;
    logic ab;
    free_at = 0;
    drops   = m_drop;
    for (int c = 0; c <= MAXN; c++) begin
      e_wr[c]   = 1'b0;
      e_dat[c]  = '0;
      e_busy[c] = 1'b0;
      e_drop[c] = '0;
    end
    e_drop[0] = 16'(drops);
    for (int t = 0; t < seg_len; t++) begin
      if (s_trig[t] && s_arm[t]) begin
        if (t < free_at) begin
          drops++;
        end else if (s_rdy[t] && s_n[t] != 8'd0 && int'(s_space[t]) >= int'(s_n[t]) + 3) begin
          n  = int'(s_n[t]);
          w  = n;
          ab = 1'b0;
          for (int j = 1; j < n; j++) begin
            if (!s_rdy[t+j]) begin
              w  = j;
              ab = 1'b1;
              break;
            end
          end
          for (int i = 0; i < w; i++) begin
            e_wr[t+1+i]  = 1'b1;
            e_dat[t+1+i] = {(i == 0) ? 2'b10 : 2'b00, s_ptb[t+i]};
          end
          e_wr[t+w+1]  = 1'b1;
          e_dat[t+w+1] = {2'b00, s_ltc[t][47:26]};
          e_wr[t+w+2]  = 1'b1;
          e_dat[t+w+2] = {2'b00, s_ltc[t][25:4]};
          e_wr[t+w+3]  = 1'b1;
          e_dat[t+w+3] = {2'b01, s_ltc[t][3:0], ab, 9'b0, 8'(w)};
          for (int b = t + 1; b <= t + w + 2; b++) e_busy[b] = 1'b1;
          free_at = t + w + 3;
        end else begin
          drops++;
        end
        if (drops > 65535) drops = 65535;
      end
      e_drop[t+1] = 16'(drops);
    end
  endtask

  // Entered and left at #1 after a rising edge
  task automatic run_seg();
    build_expect();
    wlog.delete();
    for (int c = 0; c < seg_len; c++) begin
      ptb_in     = s_ptb[c];
      ptb_rdy    = s_rdy[c];
      arm        = s_arm[c];
      trig       = s_trig[c];
      n_samples  = s_n[c];
      ltc        = s_ltc[c];
      fifo_space = s_space[c];
      @(negedge clk);
      check_val($sformatf("wr_en@%0d", c), 48'(wr_en), 48'(e_wr[c]));
      check_val($sformatf("busy@%0d", c), 48'(busy), 48'(e_busy[c]));
      check_val($sformatf("drop_cnt@%0d", c), 48'(drop_cnt), 48'(e_drop[c]));
      if (e_wr[c]) check_val($sformatf("wr_data@%0d", c), 48'(wr_data), 48'(e_dat[c]));
      if (wr_en) wlog.push_back(wr_data);
      @(posedge clk);
      #1;
    end
    m_drop = int'(e_drop[seg_len]);
  endtask

  logic [23:0] t1_exp [7];
  int          d0;

  initial begin
    rst_n      = 1'b0;
    ptb_in     = '0;
    ptb_rdy    = 1'b0;
    arm        = 1'b0;
    trig       = 1'b0;
    n_samples  = '0;
    ltc        = '0;
    fifo_space = '0;
    m_drop     = 0;

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_wr_en", 48'(wr_en), 48'd0);
    check_val("reset_wr_data", 48'(wr_data), 48'd0);
    check_val("reset_busy", 48'(busy), 48'd0);
    check_val("reset_drop_cnt", 48'(drop_cnt), 48'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counting samples, trigger when ptb_in=10
    seg_default(40);
    for (int c = 0; c < MAXN; c++) s_ptb[c] = 22'(c);
    s_trig[10] = 1'b1;
    run_seg();
    t1_exp[0] = {2'b10, 22'd10};
    t1_exp[1] = {2'b00, 22'd11};
    t1_exp[2] = {2'b00, 22'd12};
    t1_exp[3] = {2'b00, 22'd13};
    t1_exp[4] = {2'b00, 22'h048D15};
    t1_exp[5] = {2'b00, 22'h2789AB};
    t1_exp[6] = {2'b01, 4'hC, 1'b0, 9'b0, 8'd4};
    check_val("t1_nwords", 48'(wlog.size()), 48'd7);
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("t1_word%0d", i), 48'((i < wlog.size()) ? wlog[i] : 24'h0), 48'(t1_exp[i]));
    end

    // Space boundary: 6 words is too few for n=4, 7 is enough
    d0 = m_drop;
    seg_default(40);
    for (int c = 0; c < MAXN; c++) s_space[c] = (c < 12) ? 12'd6 : 12'd7;
    s_trig[5]  = 1'b1;
    s_trig[15] = 1'b1;
    run_seg();
    check_val("t2_drop", 48'(drop_cnt), 48'(d0 + 1));
    check_val("t2_nwords", 48'(wlog.size()), 48'd7);

    // ptb_rdy low at trigger is a drop; arm low is ignored
    d0 = m_drop;
    seg_default(30);
    s_rdy[5]   = 1'b0;
    s_trig[5]  = 1'b1;
    s_arm[10]  = 1'b0;
    s_trig[10] = 1'b1;
    run_seg();
    check_val("t3_drop", 48'(drop_cnt), 48'(d0 + 1));
    check_val("t3_nwords", 48'(wlog.size()), 48'd0);

    // Abort: ptb_rdy falls on the 4th capture cycle of an 8-sample event
    seg_default(40);
    for (int c = 0; c < MAXN; c++) s_n[c] = 8'd8;
    s_trig[5] = 1'b1;
    for (int c = 8; c < 12; c++) s_rdy[c] = 1'b0;
    run_seg();
    check_val("t4_nwords", 48'(wlog.size()), 48'd6);
    check_val("t4_sample2", 48'((wlog.size() > 2) ? wlog[2] : 24'h0), 48'({2'b00, s_ptb[7]}));
    check_val("t4_eof", 48'((wlog.size() > 5) ? wlog[5] : 24'h0), 48'({2'b01, 4'hC, 1'b1, 9'b0, 8'd3}));

    // Trigger during the trailer is dropped; trigger on the first IDLE cycle runs back-to-back
    d0 = m_drop;
    seg_default(50);
    s_trig[5]  = 1'b1;
    s_trig[10] = 1'b1;
    s_trig[12] = 1'b1;
    run_seg();
    check_val("t5_drop", 48'(drop_cnt), 48'(d0 + 1));
    check_val("t5_nwords", 48'(wlog.size()), 48'd14);
    check_val("t5_sof2", 48'((wlog.size() > 7) ? wlog[7] : 24'h0), 48'({2'b10, s_ptb[12]}));

    // Randomized segments: triggers in the first 500 cycles, then a quiet tail that lets every event finish
    for (int s = 0; s < 6; s++) begin
      seg_default(800);
      for (int c = 0; c < 500; c++) begin
        s_ltc[c]   = 48'({$urandom(), $urandom()});
        s_trig[c]  = ($urandom_range(0, 5) == 0);
        s_arm[c]   = ($urandom_range(0, 7) != 0);
        s_rdy[c]   = ($urandom_range(0, 24) != 0);
        s_n[c]     = ($urandom_range(0, 30) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
        s_space[c] = ($urandom_range(0, 3) == 0) ? 12'hFFF
                                                 : 12'(int'(s_n[c]) + int'($urandom_range(1, 5)));
      end
      run_seg();
    end

    // Reset mid-capture drops wr_en and busy at once and clears drop_cnt
    trig       = 1'b1;
    arm        = 1'b1;
    ptb_rdy    = 1'b1;
    n_samples  = 8'd10;
    fifo_space = 12'hFFF;
    @(posedge clk);
    #1;
    trig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pre_wr_en", 48'(wr_en), 48'd1);
    check_val("rst_pre_busy", 48'(busy), 48'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_wr_en", 48'(wr_en), 48'd0);
    check_val("rst_mid_busy", 48'(busy), 48'd0);
    check_val("rst_mid_wr_data", 48'(wr_data), 48'd0);
    check_val("rst_mid_drop_cnt", 48'(drop_cnt), 48'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_drop = 0;
    @(negedge clk);
    check_val("rst_post_wr_en", 48'(wr_en), 48'd0);
    check_val("rst_post_busy", 48'(busy), 48'd0);
    @(posedge clk);
    #1;

    // drop_cnt saturation
    trig    = 1'b1;
    arm     = 1'b1;
    ptb_rdy = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check_val("sat_fffe", 48'(drop_cnt), 48'hFFFE);
    @(posedge clk);
    #1;
    check_val("sat_ffff", 48'(drop_cnt), 48'hFFFF);
    @(posedge clk);
    #1;
    trig = 1'b0;
    check_val("sat_hold", 48'(drop_cnt), 48'hFFFF);
    check_val("sat_no_wr", 48'(wr_en), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
